// File: rtl/fugue_pkg.sv
// Shared constants and types for the Fugue SMIX sharing logic.
package fugue_pkg;
    localparam int SMIX_W   = 128;
    localparam int SMIX_LAT = 1;

    typedef logic [31:0]       smix_word_t;
    typedef logic [SMIX_W-1:0] smix_blk_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/fugue_resp_fifo.sv
// First-word-fall-through response FIFO; count feeds the issue credit check.
module fugue_resp_fifo
    import fugue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 130,
    localparam int CNT_W = clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Empty head reads as zero so the response port is quiet when idle.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/fugue_smix_arb.sv
// Round-robin arbiter sharing one registered SMIX datapath among NUM_REQ requesters,
// with credit-throttled issue into a FWFT response FIFO.
module fugue_smix_arb
    import fugue_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*SMIX_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [31:0]               smix_s0,
    output logic [31:0]               smix_s1,
    output logic [31:0]               smix_s2,
    output logic [31:0]               smix_s3,
    input  logic [SMIX_W-1:0]         smix_out,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [SMIX_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy,
    output logic [31:0]               issue_count
);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]                 ptr, gnt_idx;
    logic                            gnt_found, credit_ok, issue, inflight;
    logic [SMIX_LAT-1:0]             vld_pipe;
    logic [SMIX_LAT-1:0][ID_W-1:0]   id_pipe;
    logic [CNT_W:0]                  credit_used;
    logic [CNT_W-1:0]                fifo_count;
    logic                            fifo_empty;
    smix_blk_t                       gnt_blk;
    int                              idx;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    // Same-cycle pops are ignored, so this never over-commits the FIFO.
    always_comb begin
        credit_used = {1'b0, fifo_count};
        for (int s = 0; s < SMIX_LAT; s++) credit_used = credit_used + (CNT_W+1)'(vld_pipe[s]);
    end

    assign credit_ok = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    assign issue     = gnt_found && credit_ok;
    assign req_ready = issue ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign gnt_blk   = issue ? req_data[int'(gnt_idx)*SMIX_W +: SMIX_W] : '0;
    assign smix_s0   = gnt_blk[127:96];
    assign smix_s1   = gnt_blk[95:64];
    assign smix_s2   = gnt_blk[63:32];
    assign smix_s3   = gnt_blk[31:0];
    assign inflight  = |vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
            issue_count <= '0;
        end else begin
            vld_pipe[0] <= issue;
            id_pipe[0]  <= gnt_idx;
            for (int s = 1; s < SMIX_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            if (issue) begin
                ptr         <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                issue_count <= issue_count + 32'd1;
            end
        end
    end

    fugue_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ID_W + SMIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_pipe[SMIX_LAT-1]),
        .push_data ({id_pipe[SMIX_LAT-1], smix_out}),
        .pop       (resp_valid && resp_ready),
        .head      ({resp_id, resp_data}),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign busy       = inflight || !fifo_empty;
endmodule

// File: tb/tb_fugue_smix_arb.sv
// Directed bench for fugue_smix_arb with a registered stand-in SMIX datapath.
module tb_fugue_smix_arb;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req_valid = '0;
    logic [511:0]   req_data = '0;
    logic [3:0]     req_ready;
    logic [31:0]    smix_s0, smix_s1, smix_s2, smix_s3;
    logic [127:0]   smix_out = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [127:0]   resp_data;
    logic [1:0]     resp_id;
    logic           busy;
    logic [31:0]    issue_count;

    typedef struct packed { logic [1:0] id; logic [127:0] data; } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    fugue_smix_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .smix_s0(smix_s0), .smix_s1(smix_s1), .smix_s2(smix_s2),
        .smix_s3(smix_s3), .smix_out(smix_out), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Stand-in SMIX: rotate by one word and xor a fixed pattern, one register stage.
    function automatic logic [127:0] smix_f(input logic [127:0] x);
        return {x[95:0], x[127:96]} ^ {4{32'hC6C6_63A5}};
    endfunction

    always @(posedge clk) smix_out <= smix_f({smix_s0, smix_s1, smix_s2, smix_s3});

    function automatic logic [127:0] op(input int i, input int n);
        logic [31:0] t;
        t = 32'hA000_0000 | (i << 16) | n;
        return {t, ~t, t ^ 32'h5A5A_5A5A, t + 32'd1};
    endfunction

    task automatic set_op(input int i, input int n);
        req_data[i*128 +: 128] = op(i, n);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Every popped response must match the next expected (id, data) in issue order.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_order: got id=%0d data=%h, required no response", resp_id, resp_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_id, resp_data} !== mon_e) begin
                    n_err++;
                    $display("FAIL resp_order: got id=%0d data=%h, required id=%0d data=%h",
                             resp_id, resp_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({req_ready, resp_valid, busy, issue_count, resp_data, resp_id, smix_s0, smix_s1, smix_s2, smix_s3} !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b rv=%b busy=%b cnt=%0d id=%0d, required all zero",
                     req_ready, resp_valid, busy, issue_count, resp_id);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        resp_ready = 1'b1;
        req_data = '0;
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 128'hC6C663A5_C6C663A5_C6C663A5_C6C663A5});
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_grant: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_t1: got rv=%b busy=%b, required rv=0 busy=1", resp_valid, busy);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data[127:112] !== 16'hC6C6) begin
            n_err++; $display("FAIL single_resp: got rv=%b id=%0d top=%h, required rv=1 id=0 top=c6c6",
                              resp_valid, resp_id, resp_data[127:112]);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got rv=%b busy=%b, required 0 0", resp_valid, busy);
        end
    endtask

    task automatic run_grants(input int n, input int seq_g[8], inout int seq[4]);
        logic [127:0] d;
        int g;
        for (int k = 0; k < n; k++) begin
            g = seq_g[k];
            exp_q.push_back({2'(g), smix_f(op(g, seq[g]))});
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'(1 << g)) begin
                n_err++; $display("FAIL grant_%0d: got %b, required %b", k, req_ready, 4'(1 << g));
            end
            if (k == 0) begin
                d = op(g, seq[g]);
                n_cmp++;
                if ({smix_s0, smix_s1, smix_s2, smix_s3} !== d) begin
                    n_err++; $display("FAIL smix_drive: got %h %h %h %h, required %h",
                                      smix_s0, smix_s1, smix_s2, smix_s3, d);
                end
            end
            tick();
            seq[g]++;
            set_op(g, seq[g]);
        end
    endtask

    task automatic check_drained(input string name, input logic [31:0] cnt);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0 || issue_count !== cnt) begin
            n_err++; $display("FAIL %s_drain: left=%0d busy=%b cnt=%0d, required 0 0 %0d",
                              name, exp_q.size(), busy, issue_count, cnt);
        end
    endtask

    task automatic test_round_robin;
        int seq[4];
        int gs[8];
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; set_op(i, 0); end
        gs = '{0, 1, 2, 3, 0, 1, 2, 3};
        req_valid = 4'hF;
        run_grants(8, gs, seq);
        req_valid = '0;
        repeat (4) tick();
        check_drained("rr", 32'd8);
    endtask

    task automatic test_sparse;
        int seq[4];
        int gs[8];
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; set_op(i, 0); end
        gs = '{1, 0, 0, 0, 0, 0, 0, 0};
        req_valid = 4'b0010;
        run_grants(1, gs, seq);
        gs = '{3, 1, 3, 0, 0, 0, 0, 0};
        req_valid = 4'b1010;
        run_grants(3, gs, seq);
        req_valid = '0;
        repeat (4) tick();
        check_drained("sparse", 32'd4);
    endtask

    task automatic test_back_pressure;
        int seq[4];
        int gs[8];
        do_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; set_op(i, 0); end
        gs = '{0, 1, 2, 3, 0, 0, 0, 0};
        req_valid = 4'hF;
        run_grants(4, gs, seq);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || busy !== 1'b1) begin
                n_err++; $display("FAIL bp_stall_%0d: got rdy=%b rv=%b busy=%b, required 0000 1 1",
                                  c, req_ready, resp_valid, busy);
            end
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL bp_pop_cycle: got %b, required 0000", req_ready);
        end
        tick();
        resp_ready = 1'b0;
        gs = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_grants(1, gs, seq);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_restall_%0d: got %b, required 0000", c, req_ready);
            end
            tick();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (8) tick();
        check_drained("bp", 32'd5);
    endtask

    task automatic test_reset_mid_op;
        int seq[4];
        int gs[8];
        do_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; set_op(i, 0); end
        gs = '{0, 1, 2, 0, 0, 0, 0, 0};
        req_valid = 4'hF;
        run_grants(3, gs, seq);
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, busy, issue_count, resp_data, resp_id} !== '0) begin
            n_err++; $display("FAIL async_reset: rdy=%b rv=%b busy=%b cnt=%0d id=%0d, required all zero",
                              req_ready, resp_valid, busy, issue_count, resp_id);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b0) begin
                n_err++; $display("FAIL post_reset_rv_%0d: got %b, required 0", c, resp_valid);
            end
            tick();
        end
        set_op(1, 7);
        set_op(3, 7);
        seq[1] = 7;
        seq[3] = 7;
        gs = '{1, 0, 0, 0, 0, 0, 0, 0};
        req_valid = 4'b1010;
        run_grants(1, gs, seq);
        req_valid = '0;
        repeat (3) tick();
        check_drained("rst", 32'd1);
    endtask

    task automatic test_idle;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({smix_s0, smix_s1, smix_s2, smix_s3} !== '0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
                n_err++; $display("FAIL idle_%0d: got s0=%h busy=%b rv=%b, required 0 0 0",
                                  c, smix_s0, busy, resp_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_back_pressure();
        test_reset_mid_op();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
